bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial shifter with valid/ready word handshake
//
// Accepts a WIDTH-bit word on load_valid && load_ready and shifts it out on
// sout, one bit per clk, starting the cycle after acceptance. Back-to-back
// words are sent with no gap cycles.
//
// Ports:
//   clk         rising-edge clock
//   clr         asynchronous active-high reset
//   load_data   parallel word to serialize
//   load_valid  load_data holds a word to send
//   load_ready  block can accept a word this cycle
//   msb_first   bit order of the word being accepted (1 = MSB first)
//   sout        registered serial bit stream
//   sout_valid  sout carries a data bit this cycle
//   busy        a word is in progress
//   bit_idx     position of the bit on sout, 0 = first bit sent
//   words_sent  accepted-word count, modulo 256

module bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0,
    localparam int  IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             msb_first,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic [IDX_W-1:0] bit_idx,
    output logic [7:0]       words_sent
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_msb;
    logic             r_sout;
    logic [IDX_W-1:0] r_bit_idx;
    logic [7:0]       r_words;
    logic             w_last;
    logic             w_accept;

    // The last bit of a word is the only SHIFT cycle that can take a new word,
    // which is what lets consecutive words run without a gap.
    assign w_last     = (r_state == S_SHIFT) && (r_bit_idx == LAST_IDX);
    assign load_ready = (r_state == S_IDLE) || w_last;
    assign w_accept   = load_valid && load_ready;

    assign sout       = r_sout;
    assign sout_valid = (r_state == S_SHIFT);
    assign busy       = (r_state == S_SHIFT);
    assign bit_idx    = r_bit_idx;
    assign words_sent = r_words;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last && !w_accept) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // The first bit is registered straight from load_data so it shows on sout
    // the cycle after acceptance. r_shift keeps the bit currently on sout in
    // its leading position, so the next bit is always its neighbour.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_shift   <= '0;
            r_msb     <= 1'b0;
            r_sout    <= IDLE_BIT;
            r_bit_idx <= '0;
            r_words   <= 8'd0;
        end else if (w_accept) begin
            r_shift   <= load_data;
            r_msb     <= msb_first;
            r_sout    <= msb_first ? load_data[WIDTH-1] : load_data[0];
            r_bit_idx <= '0;
            r_words   <= r_words + 8'd1;
        end else if (r_state == S_SHIFT) begin
            if (w_last) begin
                r_sout    <= IDLE_BIT;
                r_bit_idx <= '0;
            end else begin
                if (r_msb) begin
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    r_sout  <= r_shift[WIDTH-2];
                end else begin
                    r_shift <= {1'b0, r_shift[WIDTH-1:1]};
                    r_sout  <= r_shift[1];
                end
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
        end
    end

endmodule
